// File: rtl/rr_stream_mux.sv
// rr_stream_mux: round-robin N_IN-to-1 valid/ready stream multiplexer with
// packet locking. A port that wins arbitration with a non-last beat keeps the
// grant until its last beat transfers, so packets are never interleaved on
// the output. The output is a single registered beat tagged with its source.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_last      per-port beat valid and end-of-packet marker
//   in_data               per-port data, port i at [i*DATA_W +: DATA_W]
//   in_ready              per-port accept (one-hot or zero)
//   out_valid/out_ready   output handshake
//   out_data/out_sel      registered output beat and its source port index
//   out_last              end-of-packet marker of the output beat

// Per-port request qualification and ready generation.
module rr_stream_mux_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             rst_n,
  input  logic             lock_mode,
  input  logic [SEL_W-1:0] lock_idx,
  input  logic             valid,
  input  logic             grant,
  input  logic             load_en,
  output logic             req,
  output logic             ready
);
  // While locked, only the owning port may request.
  assign req   = valid && (!lock_mode || (lock_idx == SEL_W'(IDX)));
  assign ready = grant && load_en && rst_n;
endmodule

module rr_stream_mux #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN-1:0]        in_valid,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [N_IN-1:0]        in_last,
  output logic [N_IN-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_last,
  input  logic                   out_ready
);
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              last;
  } beat_t;

  state_t                       state_q, state_d;
  logic   [SEL_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic   [SEL_W-1:0]           lock_idx_q, lock_idx_d;
  logic                         out_valid_q, out_valid_d;
  beat_t                        out_q, out_d;

  logic   [N_IN-1:0][DATA_W-1:0] in_data_a;
  logic   [N_IN-1:0]            req;
  logic   [N_IN-1:0]            gnt_vec;
  logic   [SEL_W-1:0]           gnt_idx;
  logic                         gnt_any;
  logic                         load_en;
  logic                         xfer;

  assign in_data_a = in_data;
  assign load_en   = !out_valid_q || out_ready;
  assign xfer      = gnt_any && load_en && rst_n;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
    if (int'(idx) == N_IN - 1) wrap_inc = '0;
    else                       wrap_inc = idx + 1'b1;
  endfunction

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    rr_stream_mux_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .rst_n     (rst_n),
      .lock_mode (state_q == LOCK),
      .lock_idx  (lock_idx_q),
      .valid     (in_valid[i]),
      .grant     (gnt_vec[i]),
      .load_en   (load_en),
      .req       (req[i]),
      .ready     (in_ready[i])
    );
  end

  // Rotating priority search starting at rr_ptr. In LOCK only the owner
  // requests, so the same search yields the locked port or nothing.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vec = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int off = 0; off < N_IN; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      case (state_q)
        ARB: begin
          if (in_last[gnt_idx]) begin
            rr_ptr_d = wrap_inc(gnt_idx);
          end else begin
            state_d    = LOCK;
            lock_idx_d = gnt_idx;
          end
        end
        LOCK: begin
          if (in_last[gnt_idx]) begin
            state_d  = ARB;
            rr_ptr_d = wrap_inc(lock_idx_q);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // Output register: refills whenever empty or draining; data is left as-is
  // when it empties so only out_valid toggles.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (load_en) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_d.data = in_data_a[gnt_idx];
        out_d.sel  = gnt_idx;
        out_d.last = in_last[gnt_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_sel   = out_q.sel;
  assign out_last  = out_q.last;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Randomized bench for rr_stream_mux with a scoreboard. The driver runs a
// reference arbiter built from the round-robin/lock rules and pushes every
// beat it expects to be accepted; the monitor pops and compares as beats
// appear on the output.
module tb_rr_stream_mux;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid, in_last, in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_last, out_ready;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;

  rr_stream_mux #(.N_IN(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t sbq[$];
  int   sel_log[$];
  bit   log_on = 0;
  int   total = 0;
  int   bad = 0;

  // reference model state
  int   m_ptr, m_lock_port;
  bit   m_locked, m_full;
  int   exp_g;
  logic [N-1:0] exp_ready;

  // sources
  int         pk_left[N];
  logic [N-1:0] cur_v, cur_l;
  logic [7:0] cur_d[N];
  logic [N-1:0] port_en;
  int   p_valid, max_len, p_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int mdl_grant();
    if (m_locked) return cur_v[m_lock_port] ? m_lock_port : -1;
    for (int off = 0; off < N; off++)
      if (cur_v[(m_ptr + off) % N]) return (m_ptr + off) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_lock_port = 0; m_locked = 0; m_full = 0;
    for (int i = 0; i < N; i++) pk_left[i] = 0;
    cur_v = '0; cur_l = '0;
    sbq.delete();
  endtask

  // Applies the decision taken for the inputs that were present at the edge.
  task automatic model_update();
    bit le;
    int g;
    exp_t e;
    le = !m_full || out_ready;
    g  = exp_g;
    if (le && g >= 0) begin
      e.sel = g; e.d = cur_d[g]; e.l = cur_l[g];
      sbq.push_back(e);
      if (m_locked) begin
        if (cur_l[g]) begin m_locked = 0; m_ptr = (g + 1) % N; end
      end else if (cur_l[g]) m_ptr = (g + 1) % N;
      else begin m_locked = 1; m_lock_port = g; end
      m_full = 1;
      cur_v[g] = 1'b0;
      pk_left[g]--;
    end else if (le) m_full = 0;
  endtask

  task automatic gen_drive();
    bit le;
    for (int i = 0; i < N; i++) begin
      if (!cur_v[i] && (port_en[i] || pk_left[i] > 0) && $urandom_range(99) < p_valid) begin
        if (pk_left[i] == 0) pk_left[i] = $urandom_range(max_len, 1);
        cur_d[i] = 8'($urandom);
        cur_l[i] = (pk_left[i] == 1);
        cur_v[i] = 1'b1;
      end
    end
    out_ready = ($urandom_range(99) < p_ready);
    in_valid  = cur_v;
    in_last   = cur_l;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = cur_d[i];
    exp_g = mdl_grant();
    le = !m_full || out_ready;
    exp_ready = (rst_n && le && exp_g >= 0) ? (N'(1) << exp_g) : '0;
  endtask

  task automatic cycle();
    @(posedge clk); #2;
    if (rst_n) model_update();
    gen_drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // monitor
  bit          prev_le = 1;
  logic [10:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      prev_le = 1;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      if (prev_le) begin
        if (out_valid) begin
          if (sbq.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("out_sel", 32'(out_sel), 32'(e.sel));
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_last", 32'(out_last), 32'(e.l));
            if (log_on) sel_log.push_back(int'(out_sel));
          end
        end else chk("missing_beat", sbq.size(), 0);
      end else begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_beat", 32'({out_sel, out_last, out_data}), 32'(held));
      end
      prev_le = !out_valid || out_ready;
      held    = {out_sel, out_last, out_data};
    end
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    port_en = '1; p_valid = 100; max_len = 1; p_ready = 100;
    gen_drive();
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_sel", 32'(out_sel), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_in_valid_all", 32'(in_valid), 32'hF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    gen_drive();

    // fairness: all ports valid, single beats, full rate
    log_on = 1;
    run(8);
    log_on = 0;
    chk("fair_count", 32'(sel_log.size() >= 6), 1);
    if (sel_log.size() >= 6) begin
      chk("fair_sel0", 32'(sel_log[0]), 0);
      chk("fair_sel1", 32'(sel_log[1]), 1);
      chk("fair_sel2", 32'(sel_log[2]), 2);
      chk("fair_sel3", 32'(sel_log[3]), 3);
      chk("fair_sel4", 32'(sel_log[4]), 0);
      chk("fair_sel5", 32'(sel_log[5]), 1);
    end

    // backpressure
    p_ready = 0;   run(5);
    p_ready = 100; run(4);

    // wrap-around: only port 3, then ports 0 and 3
    port_en = '0;      run(10);
    port_en = 4'b1000; run(6);
    port_en = 4'b1001; run(10);

    // random multi-beat packets with gaps and backpressure
    port_en = '1; max_len = 5;
    p_valid = 60;  p_ready = 70;  run(1500);
    p_valid = 100; p_ready = 100; run(300);
    p_valid = 70;  p_ready = 20;  run(300);

    // drain, then reset during beat 2 of a 4-beat port-0 packet
    port_en = '0; p_valid = 100; p_ready = 100; run(40);
    chk("drain_empty", sbq.size() == 0 && !out_valid ? 1 : 0, 1);
    port_en = 4'b0001; pk_left[0] = 4;
    run(2);
    @(posedge clk); #2;
    model_update();
    chk("mid_pkt_beat2_pending", sbq.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    model_reset();
    port_en = '0;
    gen_drive();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    port_en = 4'b0100; max_len = 1;
    sel_log.delete();
    gen_drive();
    log_on = 1;
    run(5);
    log_on = 0;
    chk("post_rst_count", 32'(sel_log.size() > 0), 1);
    if (sel_log.size() > 0) chk("post_rst_sel", 32'(sel_log[0]), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Round-robin N-to-1 stream multiplexer with packet locking. It merges up to N_IN valid/ready input streams onto one registered output stream. Each output beat is tagged with the index of its source port, so a downstream 1-to-N demultiplexer can route it back. It sits at the convergence point of the data path, opposite the distribution demultiplexers.

## Interface
- N_IN, 4, number of input ports (2..16)
- DATA_W, 8, data width per beat
- SEL_W, $clog2(N_IN), width of the source tag
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N_IN  per-port beat valid
- in_data  input  N_IN*DATA_W  per-port data; port i occupies bits [i*DATA_W +: DATA_W]
- in_last  input  N_IN  per-port end-of-packet marker, qualified by in_valid
- in_ready  output  N_IN  per-port accept; at most one bit high per cycle
- out_valid  output  1  output beat valid
- out_data  output  DATA_W  output data
- out_sel  output  SEL_W  source port index of the current output beat
- out_last  output  1  end-of-packet marker of the current output beat
- out_ready  input  1  downstream accept

## Operation
- A transfer occurs on a port when valid and ready are both high at a rising clk edge.
- Output register: a single entry holding out_data, out_sel and out_last, with out_valid as its full flag.
  - load_en = !out_valid || out_ready.
  - When load_en is high and a beat is granted, the register loads that beat and out_valid is 1.
  - When load_en is high and no beat is granted, out_valid clears to 0.
- in_ready[i] = grant[i] && load_en. This is a combinational path from out_ready to in_ready.
- While out_valid && !out_ready, out_data, out_sel and out_last are held stable.
- FSM states:
  - ARB: grant goes to the first port with in_valid set, searching upward from rr_ptr and wrapping modulo N_IN.
    - A granted beat with in_last=1 stays in ARB, and rr_ptr = granted index + 1 (mod N_IN).
    - A granted beat with in_last=0 moves to LOCK, with lock_idx = granted index.
  - LOCK: only port lock_idx may be granted, when its in_valid is high.
    - Other ports get in_ready=0 even if the locked port is idle.
    - Transferring a beat with in_last=1 returns to ARB, and rr_ptr = lock_idx + 1 (mod N_IN).
- Pointer wrap-around: index N_IN-1 + 1 wraps to 0.
- Arbitration and pointer updates happen only on actual input transfers. If load_en is low, the grant decision is recomputed next cycle and the pointer does not change.
- A packet may be a single beat (in_last=1 on its first beat).
- Reset (asynchronous assert, synchronous release):
  - state = ARB, rr_ptr = 0, lock_idx = 0.
  - out_valid = 0, out_data = 0, out_sel = 0, out_last = 0.
  - in_ready = 0 while rst_n is low.
  - Reset mid-packet drops the partial packet. No recovery is attempted.

## Timing
- Latency: a beat accepted at edge k appears on out_* immediately after edge k. Input-to-output is one cycle.
- Throughput: one beat per cycle when out_ready is held high.
- The output holds data for any number of out_ready=0 cycles without loss or duplication.
- Simultaneous events:
  - The output draining and a new beat loading at the same edge is a legal full-rate transfer.
  - The last beat of a locked packet and a competing request in the same cycle: the competing request is granted on the next cycle at the earliest.
- No combinational path from in_valid/in_data to out_*. All output signals are registered.

## Test plan
- Reset check: assert rst_n=0 with all in_valid=1. Required: out_valid=0, out_sel=0, all in_ready=0. After release with out_ready=1, the first output beat has out_sel=0.
- Round-robin fairness: N_IN=4, all ports continuously valid with single-beat packets (in_last=1), out_ready=1. Required: out_sel sequence 0,1,2,3,0,1, one beat per cycle.
- Packet lock:
  - Port 1 sends 3 beats (0xA1, 0xA2, 0xA3, last on the third) while port 2 is continuously valid.
  - Required: out_data 0xA1, 0xA2, 0xA3 with out_sel=1 contiguously, then out_sel=2.
  - Inserting a gap in port 1's valid stalls the output. Port 2 is not granted during the gap.
- Backpressure: out_ready=0 for 5 cycles with a beat 0x5C held in the register. Required: out_data=0x5C stable, all in_ready=0, and no beat lost or duplicated after out_ready returns to 1.
- Wrap-around: only port 3 valid (single beats), then ports 0 and 3 valid. Required: after a port-3 grant, the next grant is port 0.
- Reset mid-packet: assert rst_n during beat 2 of a 4-beat port-0 packet. Required: out_valid=0 immediately and state=ARB. A new single-beat packet on port 2 then passes with out_sel=2.
